// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber for a SECDED (13-bit codeword, 8 data bits) word memory.
// Walks addresses 0..DEPTH-1 when started, reads each codeword, writes back the corrected
// codeword on a single-bit error, counts corrected and uncorrectable words, and captures the
// address of the first uncorrectable word. Yields the memory port whenever host_busy_i is high.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              one-cycle pulse, starts a pass when idle
//   clear_i              zeroes counters, err_valid_o and err_addr_o
//   host_busy_i          host owns the memory this cycle
//   mem_re_o, mem_we_o   registered read / write strobes (never both high)
//   mem_addr_o           registered access address
//   mem_wdata_o          registered corrected codeword for write-back
//   mem_rdata_i          read codeword, decoded in the cycle mem_re_o is high
//   busy_o, done_o       pass in progress / one-cycle end-of-pass pulse
//   corr_count_o         saturating count of corrected words
//   uncorr_count_o       saturating count of uncorrectable words
//   err_valid_o          err_addr_o holds a captured address
//   err_addr_o           address of the first uncorrectable word since clear
module ecc_scrubber #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              host_busy_i,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [12:0]       mem_wdata_o,
    input  logic [12:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  corr_count_o,
    output logic [CNT_W-1:0]  uncorr_count_o,
    output logic              err_valid_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    typedef enum logic [1:0] {StIdle, StRd, StChk, StWb} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CntMax   = '1;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mem_re_q, mem_we_q, busy_q, done_q, err_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q, err_addr_q;
    logic [12:0]         mem_wdata_q;
    logic [CNT_W-1:0]    corr_q, uncorr_q;

    logic [3:0]  syndrome;
    logic        par, correctable, uncorrectable, advance;
    logic [12:0] fixed;

    // SECDED decode of the word being returned during CHK.
    always_comb begin
        syndrome = 4'd0;
        for (int unsigned i = 1; i < 13; i++) begin
            if (mem_rdata_i[i]) syndrome = syndrome ^ 4'(i);
        end
        par           = ^mem_rdata_i;
        // Syndromes 13..15 point outside the codeword, so they cannot be a single error.
        correctable   = par && (syndrome < 4'd13);
        uncorrectable = (par && (syndrome >= 4'd13)) || (!par && (syndrome != 4'd0));
        // Syndrome 0 with odd parity flips bit 0, the overall parity bit.
        fixed         = correctable ? (mem_rdata_i ^ (13'd1 << syndrome)) : mem_rdata_i;
        advance       = ((state_q == StChk) && !correctable) ||
                        ((state_q == StWb) && !host_busy_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            corr_q      <= '0;
            uncorr_q    <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start_i && !done_q) begin
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    if (!host_busy_i) begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        state_q    <= StChk;
                    end
                end
                StChk: begin
                    if (correctable) begin
                        mem_wdata_q <= fixed;
                        state_q     <= StWb;
                    end
                end
                StWb: begin
                    // mem_addr_q still holds this word's address from the read.
                    if (!host_busy_i) mem_we_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase

            if (advance) begin
                if (addr_q == LastAddr) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    addr_q  <= addr_q + 1'b1;
                    state_q <= StRd;
                end
            end

            // clear overrides any same-cycle increment or capture.
            if (clear_i) begin
                corr_q      <= '0;
                uncorr_q    <= '0;
                err_valid_q <= 1'b0;
                err_addr_q  <= '0;
            end else if (state_q == StChk) begin
                if (correctable && (corr_q != CntMax)) corr_q <= corr_q + 1'b1;
                if (uncorrectable) begin
                    if (uncorr_q != CntMax) uncorr_q <= uncorr_q + 1'b1;
                    if (!err_valid_q) begin
                        err_valid_q <= 1'b1;
                        err_addr_q  <= addr_q;
                    end
                end
            end
        end
    end

    assign mem_re_o       = mem_re_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign corr_count_o   = corr_q;
    assign uncorr_count_o = uncorr_q;
    assign err_valid_o    = err_valid_q;
    assign err_addr_o     = err_addr_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber: scoreboard of expected memory accesses, cycle-accurate
// pass-length model, counter/capture model, plus a small CNT_W=2 instance for saturation.
module tb_ecc_scrubber;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [12:0] data;
    } acc_t;

    logic        clk, rst_n, start, clear, host_busy;
    logic        mem_re, mem_we, busy, done, err_valid;
    logic [3:0]  mem_addr, err_addr;
    logic [12:0] mem_wdata, mem_rdata;
    logic [7:0]  corr_count, uncorr_count;

    logic        s_start, s_clear, s_hb, s_re, s_we, s_busy, s_done, s_ev;
    logic [2:0]  s_addr, s_ea;
    logic [12:0] s_wdata, s_rdata;
    logic [1:0]  s_corr, s_unc;

    logic [12:0] mem [16];
    logic [12:0] mem2 [8];
    logic [12:0] model_mem [16];
    logic        ld_en, ld_sel;
    logic [3:0]  ld_addr;
    logic [12:0] ld_data;

    acc_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_corr, exp_unc, exp_ea;
    bit   exp_ev;
    bit   prev_hb;

    ecc_scrubber #(.DEPTH(16), .ADDR_W(4), .CNT_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear), .host_busy_i(host_busy),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .corr_count_o(corr_count),
        .uncorr_count_o(uncorr_count), .err_valid_o(err_valid), .err_addr_o(err_addr)
    );

    ecc_scrubber #(.DEPTH(8), .ADDR_W(3), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .clear_i(s_clear), .host_busy_i(s_hb),
        .mem_re_o(s_re), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .mem_rdata_i(s_rdata), .busy_o(s_busy), .done_o(s_done), .corr_count_o(s_corr),
        .uncorr_count_o(s_unc), .err_valid_o(s_ev), .err_addr_o(s_ea)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The registered mem_addr/mem_re act as the RAM's input register, so data is presented
    // while the strobe is high. Outside a read the bus carries an uncorrectable word.
    assign mem_rdata = mem_re ? mem[mem_addr] : 13'h0003;
    assign s_rdata   = s_re ? mem2[s_addr] : 13'h0003;

    always @(posedge clk) begin
        if (ld_en) begin
            if (ld_sel) mem2[ld_addr[2:0]] <= ld_data;
            else        mem[ld_addr] <= ld_data;
        end
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (s_we)   mem2[s_addr] <= s_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Access monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        acc_t e;
        if (mem_re || mem_we) begin
            check("strobe_exclusive", {31'b0, mem_re && mem_we}, 32'd0);
            check("strobe_during_host_busy", {31'b0, prev_hb}, 32'd0);
            if (exp_q.size() == 0) begin
                check("access_unexpected", {14'b0, mem_we, mem_addr, mem_wdata}, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("access", {14'b0, mem_we, mem_addr, mem_we ? mem_wdata : 13'h0},
                      {14'b0, e.we, e.addr, e.data});
            end
        end
        prev_hb = host_busy;
    end

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] cw;
        logic        b;
        int          p;
        cw = '0;
        cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
        cw[9] = d[4]; cw[10] = d[5]; cw[11] = d[6]; cw[12] = d[7];
        for (int k = 0; k < 4; k++) begin
            p = 1 << k;
            b = 1'b0;
            for (int j = 3; j < 13; j++) if (((j & p) != 0) && (j != p)) b = b ^ cw[j];
            cw[p] = b;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic bit is_valid(input logic [12:0] w);
        return encode({w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]}) == w;
    endfunction

    // 0 clean, 1 correctable (fixed returned), 2 uncorrectable: brute force over single flips.
    function automatic int classify(input logic [12:0] w, output logic [12:0] fixed);
        logic [12:0] f;
        fixed = w;
        if (is_valid(w)) return 0;
        for (int j = 0; j < 13; j++) begin
            f = w ^ (13'd1 << j);
            if (is_valid(f)) begin
                fixed = f;
                return 1;
            end
        end
        return 2;
    endfunction

    function automatic bit hb_at(input int n, input int from, input int len);
        return (len > 0) && (n >= from) && (n < from + len);
    endfunction

    task automatic model_clear();
        exp_corr = 0; exp_unc = 0; exp_ev = 1'b0; exp_ea = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".corr"}, {24'b0, corr_count}, exp_corr);
        check({tag, ".uncorr"}, {24'b0, uncorr_count}, exp_unc);
        check({tag, ".err_valid"}, {31'b0, err_valid}, {31'b0, exp_ev});
        check({tag, ".err_addr"}, {28'b0, err_addr}, exp_ea);
    endtask

    task automatic load_word(input bit sel, input int a, input logic [12:0] d);
        ld_sel = sel; ld_addr = 4'(a); ld_data = d; ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
        if (!sel) model_mem[a] = d;
    endtask

    task automatic load_zero();
        for (int a = 0; a < 16; a++) load_word(1'b0, a, 13'h0);
    endtask

    task automatic load_random();
        logic [12:0] w;
        int r, b1;
        for (int a = 0; a < 16; a++) begin
            w = encode(8'($urandom));
            r = $urandom_range(0, 7);
            b1 = $urandom_range(0, 12);
            if (r < 3) w = w ^ (13'd1 << b1);
            else if (r == 3) w = w ^ (13'd1 << b1) ^ (13'd1 << ((b1 + $urandom_range(1, 12)) % 13));
            load_word(1'b0, a, w);
        end
    endtask

    // Runs one pass: builds expectations from the model, drives stall/clear, checks the result.
    task automatic run_pass(input string name, input int hb_from, input int hb_len,
                            input int clr_cyc, input bit skip_start, input bit chain);
        int t, chk, kind, n, got;
        bit clr_done;
        logic [12:0] fx;
        t = 1; clr_done = 1'b0;
        for (int a = 0; a < 16; a++) begin
            while (hb_at(t, hb_from, hb_len)) t++;
            exp_q.push_back('{1'b0, 4'(a), 13'h0});
            chk = t + 1;
            t = t + 2;
            if (clr_cyc != 0 && !clr_done && clr_cyc < chk) begin
                model_clear(); clr_done = 1'b1;
            end
            kind = classify(model_mem[a], fx);
            if (kind == 1) begin
                if (exp_corr < 255) exp_corr++;
                exp_q.push_back('{1'b1, 4'(a), fx});
                model_mem[a] = fx;
                while (hb_at(t, hb_from, hb_len)) t++;
                t++;
            end else if (kind == 2) begin
                if (exp_unc < 255) exp_unc++;
                if (!exp_ev) begin exp_ev = 1'b1; exp_ea = a; end
            end
            if (clr_cyc == chk) begin model_clear(); clr_done = 1'b1; end
        end
        if (clr_cyc != 0 && !clr_done) model_clear();

        if (!skip_start) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 1; got = 0;
        while (n <= t + 20) begin
            host_busy = hb_at(n, hb_from, hb_len);
            clear = (n == clr_cyc);
            start = (n == 5);
            @(negedge clk);
            if (n == 1) check({name, ".busy_in_pass"}, {31'b0, busy}, 32'd1);
            if (done) begin got = n; break; end
            @(posedge clk);
            #1 n++;
        end
        host_busy = 1'b0; clear = 1'b0; start = 1'b0;
        check({name, ".done_cycle"}, got, t);
        check({name, ".busy_at_done"}, {31'b0, busy}, 32'd0);
        check_counts(name);
        if (chain) start = 1'b1;
        @(posedge clk);
        #1;
        check({name, ".done_pulse"}, {31'b0, done}, 32'd0);
        check({name, ".pending_accesses"}, exp_q.size(), 32'd0);
        if (chain) begin
            check({name, ".start_at_done_ignored"}, {31'b0, busy}, 32'd0);
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    initial begin
        int got;
        bit saw;
        rst_n = 1'b1; start = 1'b0; clear = 1'b0; host_busy = 1'b0;
        s_start = 1'b0; s_clear = 1'b0; s_hb = 1'b0;
        ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        prev_hb = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        #2;
        check("reset.outputs", {16'b0, mem_re, mem_we, busy, done, err_valid, mem_addr, err_addr,
              3'b0}, 32'd0);
        check("reset.counts", {16'b0, corr_count, uncorr_count}, 32'd0);
        check("reset.wdata", {19'b0, mem_wdata}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        load_zero();
        run_pass("clean", 0, 0, 0, 1'b0, 1'b0);

        load_word(1'b0, 5, 13'h0020);
        run_pass("single_err", 0, 0, 0, 1'b0, 1'b0);

        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
        check_counts("idle_clear");
        load_word(1'b0, 2, 13'h0001);
        run_pass("parity_err", 0, 0, 0, 1'b0, 1'b0);

        load_word(1'b0, 7, 13'h0028);
        load_word(1'b0, 9, 13'h0028);
        run_pass("double_err", 0, 0, 0, 1'b0, 1'b0);

        load_zero();
        run_pass("stall_rd3", 7, 4, 0, 1'b0, 1'b1);
        run_pass("chained", 0, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            load_random();
            run_pass($sformatf("random%0d", i), $urandom_range(1, 40), $urandom_range(0, 3),
                     (i == 2) ? $urandom_range(1, 30) : 0, 1'b0, 1'b0);
        end

        load_zero();
        load_word(1'b0, 1, 13'h0028);
        load_word(1'b0, 3, 13'h0020);
        run_pass("clear_at_chk", 0, 0, 4, 1'b0, 1'b0);

        // Saturation instance: five corrected words into a 2-bit counter.
        for (int a = 0; a < 8; a++) load_word(1'b1, a, (a < 5) ? (13'd1 << (a + 1)) : 13'h0);
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        got = 0;
        for (int n = 1; n < 60; n++) begin
            @(negedge clk);
            if (s_done) begin got = n; break; end
            @(posedge clk);
            #1;
        end
        check("sat.done_cycle", got, 32'd22);
        check("sat.corr", {30'b0, s_corr}, 32'd3);
        check("sat.uncorr", {30'b0, s_unc}, 32'd0);

        // Reset during the CHK of address 4 aborts the pass.
        load_zero();
        for (int a = 0; a < 4; a++) exp_q.push_back('{1'b0, 4'(a), 13'h0});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rst_mid.chk4_strobe", {27'b0, mem_re, mem_addr}, {27'b0, 1'b1, 4'd4});
        rst_n = 1'b0;
        #1;
        check("rst_mid.outputs", {16'b0, mem_re, mem_we, busy, done, err_valid, mem_addr,
              err_addr, 3'b0}, 32'd0);
        check("rst_mid.counts", {16'b0, corr_count, uncorr_count}, 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || mem_re || mem_we) saw = 1'b1;
        end
        check("rst_mid.stays_idle", {31'b0, saw}, 32'd0);
        check("rst_mid.pending_accesses", exp_q.size(), 32'd0);
        check_counts("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
